dct_coeff_sequencer: RTL and testbench

//   Computes one 8x8 2-D DCT coefficient F(k1,k2) by stepping n1,n2 over 0..7.

---
 rtl/dct_coeff_sequencer_if.sv | 31 +++
 rtl/dct_coeff_sequencer.sv | 156 +++++++++++++++
 tb/tb_dct_coeff_sequencer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/dct_coeff_sequencer_if.sv
// Handshake and memory/LUT bus of the DCT coefficient sequencer.
// The slave side is the sequencer; the master side is the surrounding block (buffer, LUT bank, FIFO).
interface dct_coeff_sequencer_if #(
    parameter int ACC_W = 32
);
    logic             start;
    logic [2:0]       k1;
    logic [2:0]       k2;
    logic             busy;
    logic             pix_rd_en;
    logic [5:0]       pix_addr;
    logic [7:0]       pix_data;
    logic [2:0]       lut_k1;
    logic [2:0]       lut_k2;
    logic [2:0]       lut_n1;
    logic [2:0]       lut_n2;
    logic [31:0]      lut_cos_term;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] coeff;

    modport master (
        output start, k1, k2, pix_data, lut_cos_term, out_ready,
        input  busy, pix_rd_en, pix_addr, lut_k1, lut_k2, lut_n1, lut_n2, out_valid, coeff
    );

    modport slave (
        input  start, k1, k2, pix_data, lut_cos_term, out_ready,
        output busy, pix_rd_en, pix_addr, lut_k1, lut_k2, lut_n1, lut_n2, out_valid, coeff
    );
endinterface

// File: rtl/dct_coeff_sequencer.sv
// Sequences one 8x8 DCT coefficient: 64 pixel reads, cosine LUT indexing and a
// multiply-accumulate, then presents the scaled coefficient with a valid/ready hold.
module dct_coeff_sequencer #(
    parameter int FRAC_BITS   = 8,
    parameter bit LEVEL_SHIFT = 1'b1,
    parameter int ACC_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    dct_coeff_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [5:0]              idx_q, idx_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    acc_en_q, acc_en_d;
    logic                    busy_q, busy_d;
    logic                    pix_rd_en_q, pix_rd_en_d;
    logic [2:0]              lut_k1_q, lut_k1_d;
    logic [2:0]              lut_k2_q, lut_k2_d;
    logic [2:0]              lut_n1_q, lut_n1_d;
    logic [2:0]              lut_n2_q, lut_n2_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [ACC_W-1:0] coeff_q, coeff_d;

    logic signed [8:0]       pixel_s;
    logic signed [ACC_W-1:0] p_ext_s;
    logic signed [ACC_W-1:0] cos_ext_s;
    logic signed [ACC_W-1:0] prod_s;
    logic signed [ACC_W-1:0] acc_next_s;

    // Product of the aligned pixel and cosine term, and the accumulator value it yields.
    always_comb begin
        if (LEVEL_SHIFT) begin
            pixel_s = $signed({1'b0, bus.pix_data}) - 9'sd128;
        end else begin
            pixel_s = $signed({1'b0, bus.pix_data});
        end
        p_ext_s   = ACC_W'(pixel_s);
        cos_ext_s = ACC_W'($signed(bus.lut_cos_term));
        prod_s    = p_ext_s * cos_ext_s;
        if (acc_en_q) begin
            acc_next_s = acc_q + prod_s;
        end else begin
            acc_next_s = acc_q;
        end
    end

    // Next-state and next-output computation for the sequencing FSM.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        acc_en_d    = pix_rd_en_q;
        pix_rd_en_d = pix_rd_en_q;
        lut_k1_d    = lut_k1_q;
        lut_k2_d    = lut_k2_q;
        lut_n1_d    = lut_n1_q;
        lut_n2_d    = lut_n2_q;
        out_valid_d = out_valid_q;
        coeff_d     = coeff_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d     = ST_RUN;
                    lut_k1_d    = bus.k1;
                    lut_k2_d    = bus.k2;
                    acc_d       = '0;
                    idx_d       = 6'd0;
                    pix_rd_en_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // LUT indices trail the read address by one cycle to line up with RAM latency.
                lut_n1_d = idx_q[5:3];
                lut_n2_d = idx_q[2:0];
                acc_d    = acc_next_s;
                if (idx_q == 6'd63) begin
                    state_d     = ST_DRAIN;
                    pix_rd_en_d = 1'b0;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            ST_DRAIN: begin
                acc_d       = acc_next_s;
                coeff_d     = acc_next_s >>> FRAC_BITS;
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                pix_rd_en_d = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= 6'd0;
            acc_q       <= '0;
            acc_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            pix_rd_en_q <= 1'b0;
            lut_k1_q    <= 3'd0;
            lut_k2_q    <= 3'd0;
            lut_n1_q    <= 3'd0;
            lut_n2_q    <= 3'd0;
            out_valid_q <= 1'b0;
            coeff_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            acc_en_q    <= acc_en_d;
            busy_q      <= busy_d;
            pix_rd_en_q <= pix_rd_en_d;
            lut_k1_q    <= lut_k1_d;
            lut_k2_q    <= lut_k2_d;
            lut_n1_q    <= lut_n1_d;
            lut_n2_q    <= lut_n2_d;
            out_valid_q <= out_valid_d;
            coeff_q     <= coeff_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.pix_rd_en = pix_rd_en_q;
    assign bus.pix_addr  = idx_q;
    assign bus.lut_k1    = lut_k1_q;
    assign bus.lut_k2    = lut_k2_q;
    assign bus.lut_n1    = lut_n1_q;
    assign bus.lut_n2    = lut_n2_q;
    assign bus.out_valid = out_valid_q;
    assign bus.coeff     = coeff_q;
endmodule

// File: tb/tb_dct_coeff_sequencer.sv
// Bench for dct_coeff_sequencer: pixel RAM and cosine LUT models, directed vector
// table, randomized passes against an arithmetic reference, and handshake/reset corners.
module tb_dct_coeff_sequencer;
    logic clk;
    logic reset;

    dct_coeff_sequencer_if #(.ACC_W(32)) bus ();

    dct_coeff_sequencer #(
        .FRAC_BITS  (8),
        .LEVEL_SHIFT(1'b1),
        .ACC_W      (32)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [7:0]         mem [64];
    logic signed [31:0] cos_tab [4096];
    bit                 lut_mode;
    int                 n_chk;
    int                 n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous pixel RAM with one cycle read latency.
    always @(posedge clk) begin
        if (bus.pix_rd_en) bus.pix_data <= mem[bus.pix_addr];
    end

    // Cosine LUT bank: constant 1.0 (Q8) stub or a per-(k1,k2,n1,n2) table.
    always_comb begin
        if (lut_mode) bus.lut_cos_term = cos_tab[{bus.lut_k1, bus.lut_k2, bus.lut_n1, bus.lut_n2}];
        else          bus.lut_cos_term = 32'sd256;
    end

    typedef struct {
        logic [7:0]         fill;
        logic [7:0]         p0;
        logic [2:0]         k1;
        logic [2:0]         k2;
        bit                 tab;
        logic signed [31:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // Reference: sum of level-shifted pixel times cosine, floor-divided by 256.
    function automatic longint ref_coeff(input logic [2:0] k1v, input logic [2:0] k2v, input bit tab);
        longint acc;
        longint c;
        longint q;
        logic [5:0] a;
        acc = 0;
        for (int n = 0; n < 64; n++) begin
            a = 6'(n);
            c = tab ? longint'(cos_tab[{k1v, k2v, a}]) : 64'sd256;
            acc += (longint'(mem[n]) - 128) * c;
        end
        q = acc / 256;
        if ((acc % 256 != 0) && (acc < 0)) q = q - 1;
        return q;
    endfunction

    task automatic fill_mem(input logic [7:0] fill, input logic [7:0] p0);
        for (int i = 0; i < 64; i++) mem[i] = fill;
        mem[0] = p0;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom_range(255, 0));
    endtask

    task automatic run_one(input logic [2:0] k1v, input logic [2:0] k2v,
                           input logic signed [63:0] exp, input bit do_ack, input string nm);
        int         lat;
        int         rd_cnt;
        bit         addr_ok;
        bit         lut_ok;
        bit         got;
        logic [5:0] prev_addr;
        bus.k1    = k1v;
        bus.k2    = k2v;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.k1    = ~k1v;
        bus.k2    = ~k2v;
        lat = 0; rd_cnt = 0; addr_ok = 1'b1; lut_ok = 1'b1; got = 1'b0; prev_addr = 6'd0;
        for (int n = 0; n <= 200; n++) begin
            if (n > 0) begin
                @(posedge clk); #1;
            end
            if (bus.pix_rd_en) begin
                if (bus.pix_addr != 6'(rd_cnt)) addr_ok = 1'b0;
                rd_cnt++;
            end
            if (n >= 1 && n <= 64 && {bus.lut_n1, bus.lut_n2} != prev_addr) lut_ok = 1'b0;
            prev_addr = bus.pix_addr;
            if (bus.out_valid) begin
                lat = n;
                got = 1'b1;
                break;
            end
        end
        chk({nm, " valid_seen"}, 64'(got), 64'sd1);
        chk({nm, " latency"}, 64'(lat), 64'sd65);
        chk({nm, " coeff"}, 64'($signed(bus.coeff)), exp);
        chk({nm, " rd_count"}, 64'(rd_cnt), 64'sd64);
        chk({nm, " addr_trace"}, 64'(addr_ok), 64'sd1);
        chk({nm, " lut_n_trace"}, 64'(lut_ok), 64'sd1);
        chk({nm, " lut_k"}, 64'({bus.lut_k1, bus.lut_k2}), 64'({k1v, k2v}));
        if (do_ack) begin
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
            chk({nm, " valid_drop"}, 64'({bus.out_valid, bus.busy}), 64'sd0);
        end
    endtask

    initial begin
        logic signed [63:0] e;
        logic [2:0]         rk1;
        logic [2:0]         rk2;
        bit                 ok;
        bit                 found;

        n_chk = 0; n_pass = 0;
        lut_mode = 1'b0;
        bus.start = 1'b0; bus.k1 = 3'd0; bus.k2 = 3'd0; bus.out_ready = 1'b0;
        for (int i = 0; i < 4096; i++) cos_tab[i] = 32'(int'($urandom_range(512, 0)) - 256);
        cos_tab[{3'd1, 3'd2, 3'd0, 3'd0}] = 32'sh0e7;
        fill_mem(8'd128, 8'd128);

        vecs[0] = '{fill: 8'd255, p0: 8'd255, k1: 3'd0, k2: 3'd0, tab: 1'b0, exp: 32'sd8128};
        vecs[1] = '{fill: 8'd0,   p0: 8'd0,   k1: 3'd5, k2: 3'd6, tab: 1'b0, exp: -32'sd8192};
        vecs[2] = '{fill: 8'd128, p0: 8'd255, k1: 3'd1, k2: 3'd2, tab: 1'b1, exp: 32'sd114};
        vecs[3] = '{fill: 8'd128, p0: 8'd128, k1: 3'd7, k2: 3'd7, tab: 1'b0, exp: 32'sd0};
        vecs[4] = '{fill: 8'd129, p0: 8'd1,   k1: 3'd3, k2: 3'd4, tab: 1'b0, exp: -32'sd64};
        vecs[5] = '{fill: 8'd127, p0: 8'd127, k1: 3'd2, k2: 3'd1, tab: 1'b0, exp: -32'sd64};

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_outputs", 64'({bus.busy, bus.pix_rd_en, bus.pix_addr, bus.lut_k1, bus.lut_k2,
                                  bus.lut_n1, bus.lut_n2, bus.out_valid, bus.coeff}), 64'sd0);

        for (int v = 0; v < 6; v++) begin
            fill_mem(vecs[v].fill, vecs[v].p0);
            lut_mode = vecs[v].tab;
            run_one(vecs[v].k1, vecs[v].k2, 64'(vecs[v].exp), 1'b1, $sformatf("vec%0d", v));
        end

        lut_mode = 1'b1;
        for (int r = 0; r < 6; r++) begin
            fill_rand();
            rk1 = 3'($urandom_range(7, 0));
            rk2 = 3'($urandom_range(7, 0));
            e = 64'(ref_coeff(rk1, rk2, 1'b1));
            run_one(rk1, rk2, e, 1'b1, $sformatf("rand%0d", r));
        end

        // Output held under back-pressure while start pulses are ignored.
        fill_rand();
        e = 64'(ref_coeff(3'd4, 3'd3, 1'b1));
        run_one(3'd4, 3'd3, e, 1'b0, "hold");
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.start = 1'(i % 2);
            bus.k1 = 3'($urandom_range(7, 0));
            @(posedge clk); #1;
            if (!bus.out_valid || !bus.busy || $signed(bus.coeff) != e) ok = 1'b0;
        end
        chk("hold_stable", 64'(ok), 64'sd1);
        bus.start = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.out_ready = 1'b0;
        chk("ack_with_start_ignored", 64'({bus.out_valid, bus.busy}), 64'sd0);
        @(posedge clk); #1;
        chk("stays_idle", 64'({bus.busy, bus.pix_rd_en}), 64'sd0);
        fill_rand();
        e = 64'(ref_coeff(3'd6, 3'd5, 1'b1));
        run_one(3'd6, 3'd5, e, 1'b1, "after_hold");

        // Reset in the middle of a pass, then a clean pass at k=(0,0).
        fill_rand();
        bus.k1 = 3'd3; bus.k2 = 3'd5; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.pix_addr == 6'd20 && bus.pix_rd_en) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("reach_addr20", 64'(found), 64'sd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrun_reset_outputs", 64'({bus.busy, bus.pix_rd_en, bus.pix_addr, bus.lut_k1, bus.lut_k2,
                                         bus.lut_n1, bus.lut_n2, bus.out_valid, bus.coeff}), 64'sd0);
        fill_rand();
        e = 64'(ref_coeff(3'd0, 3'd0, 1'b1));
        run_one(3'd0, 3'd0, e, 1'b1, "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
